// File: rtl/fpu_pkg.sv
// Shared FPU definitions: default field widths, the unpacked operand
// layout and field-slice helpers for IEEE-754 style operands up to 128 bits.
package fpu_pkg;

  localparam int FP_EXP_W_DEF = 11;
  localparam int FP_MAN_W_DEF = 52;

  // Widest operand the slice helpers understand (quad precision layout).
  localparam int FP_MAX_W   = 128;
  localparam int FP_EXP_MAX = 15;
  localparam int FP_MAN_MAX = 112;

  // Operand after unpacking: effective exponent (denormal reported as 1)
  // and explicit hidden bit.
  typedef struct packed {
    logic                  sign;
    logic [FP_EXP_MAX-1:0] eexp;
    logic                  hidden;
    logic [FP_MAN_MAX-1:0] man;
  } fp_unpacked_t;

  function automatic logic f_sign(input logic [FP_MAX_W-1:0] op,
                                  input int exp_w, input int man_w);
    return op[exp_w+man_w];
  endfunction

  function automatic logic [FP_EXP_MAX-1:0] f_exp(input logic [FP_MAX_W-1:0] op,
                                                  input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] t;
    t = (op >> man_w) & ~({FP_MAX_W{1'b1}} << exp_w);
    return t[FP_EXP_MAX-1:0];
  endfunction

  function automatic logic [FP_MAN_MAX-1:0] f_man(input logic [FP_MAX_W-1:0] op,
                                                  input int man_w);
    logic [FP_MAX_W-1:0] t;
    t = op & ~({FP_MAX_W{1'b1}} << man_w);
    return t[FP_MAN_MAX-1:0];
  endfunction

  function automatic fp_unpacked_t f_unpack(input logic [FP_MAX_W-1:0] op,
                                            input int exp_w, input int man_w);
    fp_unpacked_t u;
    logic [FP_EXP_MAX-1:0] e;
    e        = f_exp(op, exp_w, man_w);
    u.sign   = f_sign(op, exp_w, man_w);
    u.hidden = (e != '0);
    u.eexp   = (e == '0) ? FP_EXP_MAX'(1) : e;
    u.man    = f_man(op, man_w);
    return u;
  endfunction

endpackage

// File: rtl/fp_shift_sticky.sv
// Barrel right shift of a significand with guard/round/sticky handling.
// Build option: FP_ALIGN_STICKY_EN -- when defined, the LSB of the result
// is the OR of every bit at or below the sticky position; otherwise the
// LSB is forced to 0 (truncating alignment).
module fp_shift_sticky #(
  parameter int SIG_W   = 56,
  parameter int SHIFT_W = 11
) (
  input  logic [SIG_W-1:0]   i_sig,
  input  logic [SHIFT_W-1:0] i_shift,
  output logic [SIG_W-1:0]   o_sig
);

  logic [SIG_W-1:0] w_shifted;

  // Shift amounts >= SIG_W naturally yield zero data.
  assign w_shifted = i_sig >> i_shift;

`ifdef FP_ALIGN_STICKY_EN
  logic [SIG_W-1:0] w_keep_mask;
  logic             w_sticky;

  // Bits below the shift amount fall off; a saturated shift drops them all.
  assign w_keep_mask = {SIG_W{1'b1}} << i_shift;
  assign w_sticky    = (|(i_sig & ~w_keep_mask)) | w_shifted[0];
  assign o_sig       = {w_shifted[SIG_W-1:1], w_sticky};
`else
  assign o_sig = w_shifted & {{(SIG_W-1){1'b1}}, 1'b0};
`endif

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage operand alignment for the FP add/sub datapath: unpack and
// order by magnitude, then shift the smaller significand into place.
// Build option: FP_ALIGN_STICKY_EN (see fp_shift_sticky).
module fp_align_pipe
  import fpu_pkg::*;
#(
  parameter  int EXP_W = FP_EXP_W_DEF,
  parameter  int MAN_W = FP_MAN_W_DEF,
  localparam int W     = 1 + EXP_W + MAN_W,
  localparam int SIG_W = MAN_W + 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             sub_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] op1_sig,
  output logic [SIG_W-1:0] op2_sig,
  output logic             op1_sign,
  output logic             op2_sign,
  output logic             eff_sub,
  output logic [EXP_W-1:0] big_exp,
  output logic [EXP_W-1:0] exp_diff,
  output logic             swapped
);

  // Handshake
  logic w_s1_adv, w_s2_adv;
  logic r_vld_p1, r_vld_p2;

  assign w_s2_adv = !r_vld_p2 || out_ready;
  assign w_s1_adv = !r_vld_p1 || w_s2_adv;
  assign in_ready = w_s1_adv;

  // ---- stage 0 -> 1 : unpack and order by magnitude ----
  logic             w_a_sign, w_b_sign, w_a_hid, w_b_hid, w_swap;
  logic [EXP_W-1:0] w_a_exp, w_b_exp, w_a_eexp, w_b_eexp;
  logic [MAN_W-1:0] w_a_man, w_b_man;

  assign w_a_sign = f_sign(FP_MAX_W'(a), EXP_W, MAN_W);
  assign w_b_sign = f_sign(FP_MAX_W'(b), EXP_W, MAN_W) ^ sub_op;
  assign w_a_exp  = EXP_W'(f_exp(FP_MAX_W'(a), EXP_W, MAN_W));
  assign w_b_exp  = EXP_W'(f_exp(FP_MAX_W'(b), EXP_W, MAN_W));
  assign w_a_man  = MAN_W'(f_man(FP_MAX_W'(a), MAN_W));
  assign w_b_man  = MAN_W'(f_man(FP_MAX_W'(b), MAN_W));
  assign w_a_hid  = |w_a_exp;
  assign w_b_hid  = |w_b_exp;
  assign w_a_eexp = w_a_hid ? w_a_exp : EXP_W'(1);
  assign w_b_eexp = w_b_hid ? w_b_exp : EXP_W'(1);
  // Ties keep a as the larger operand.
  assign w_swap   = {w_b_eexp, w_b_man} > {w_a_eexp, w_a_man};

  logic             r_op1_sign_p1, r_op1_hid_p1, r_op2_sign_p1, r_op2_hid_p1, r_swap_p1;
  logic [EXP_W-1:0] r_op1_eexp_p1, r_diff_p1;
  logic [MAN_W-1:0] r_op1_man_p1, r_op2_man_p1;

  // Stage-1 register: capture ordered operands when the stage advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1      <= 1'b0;
      r_op1_sign_p1 <= 1'b0;
      r_op1_hid_p1  <= 1'b0;
      r_op1_eexp_p1 <= '0;
      r_op1_man_p1  <= '0;
      r_op2_sign_p1 <= 1'b0;
      r_op2_hid_p1  <= 1'b0;
      r_op2_man_p1  <= '0;
      r_diff_p1     <= '0;
      r_swap_p1     <= 1'b0;
    end else if (w_s1_adv) begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_swap_p1     <= w_swap;
        r_op1_sign_p1 <= w_swap ? w_b_sign : w_a_sign;
        r_op1_hid_p1  <= w_swap ? w_b_hid  : w_a_hid;
        r_op1_eexp_p1 <= w_swap ? w_b_eexp : w_a_eexp;
        r_op1_man_p1  <= w_swap ? w_b_man  : w_a_man;
        r_op2_sign_p1 <= w_swap ? w_a_sign : w_b_sign;
        r_op2_hid_p1  <= w_swap ? w_a_hid  : w_b_hid;
        r_op2_man_p1  <= w_swap ? w_a_man  : w_b_man;
        r_diff_p1     <= w_swap ? (w_b_eexp - w_a_eexp) : (w_a_eexp - w_b_eexp);
      end
    end
  end

  // ---- stage 1 -> 2 : align smaller significand ----
  logic [SIG_W-1:0] w_op2_aligned;

  fp_shift_sticky #(
    .SIG_W   (SIG_W),
    .SHIFT_W (EXP_W)
  ) u_shift (
    .i_sig   ({r_op2_hid_p1, r_op2_man_p1, 3'b000}),
    .i_shift (r_diff_p1),
    .o_sig   (w_op2_aligned)
  );

  logic [SIG_W-1:0] r_op1_sig_p2, r_op2_sig_p2;
  logic             r_op1_sign_p2, r_op2_sign_p2, r_eff_sub_p2, r_swap_p2;
  logic [EXP_W-1:0] r_big_exp_p2, r_diff_p2;

  // Stage-2 register: output holding register, frozen while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2      <= 1'b0;
      r_op1_sig_p2  <= '0;
      r_op2_sig_p2  <= '0;
      r_op1_sign_p2 <= 1'b0;
      r_op2_sign_p2 <= 1'b0;
      r_eff_sub_p2  <= 1'b0;
      r_big_exp_p2  <= '0;
      r_diff_p2     <= '0;
      r_swap_p2     <= 1'b0;
    end else if (w_s2_adv) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_op1_sig_p2  <= {r_op1_hid_p1, r_op1_man_p1, 3'b000};
        r_op2_sig_p2  <= w_op2_aligned;
        r_op1_sign_p2 <= r_op1_sign_p1;
        r_op2_sign_p2 <= r_op2_sign_p1;
        r_eff_sub_p2  <= r_op1_sign_p1 ^ r_op2_sign_p1;
        r_big_exp_p2  <= r_op1_eexp_p1;
        r_diff_p2     <= r_diff_p1;
        r_swap_p2     <= r_swap_p1;
      end
    end
  end

  assign out_valid = r_vld_p2;
  assign op1_sig   = r_op1_sig_p2;
  assign op2_sig   = r_op2_sig_p2;
  assign op1_sign  = r_op1_sign_p2;
  assign op2_sign  = r_op2_sign_p2;
  assign eff_sub   = r_eff_sub_p2;
  assign big_exp   = r_big_exp_p2;
  assign exp_diff  = r_diff_p2;
  assign swapped   = r_swap_p2;

endmodule

// File: tb/tb_fp_align_pipe.sv
// Scoreboard bench for fp_align_pipe (double precision).
module tb_fp_align_pipe;

  localparam int SIG_W = 56;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, sub_op, out_valid, out_ready;
  logic [63:0] a, b;
  logic [55:0] op1_sig, op2_sig;
  logic        op1_sign, op2_sign, eff_sub, swapped;
  logic [10:0] big_exp, exp_diff;

  fp_align_pipe #(.EXP_W(11), .MAN_W(52)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub_op(sub_op), .out_valid(out_valid), .out_ready(out_ready),
    .op1_sig(op1_sig), .op2_sig(op2_sig), .op1_sign(op1_sign), .op2_sign(op2_sign),
    .eff_sub(eff_sub), .big_exp(big_exp), .exp_diff(exp_diff), .swapped(swapped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [55:0] op1_sig;
    logic [55:0] op2_sig;
    logic        op1_sign;
    logic        op2_sign;
    logic        eff_sub;
    logic [10:0] big_exp;
    logic [10:0] exp_diff;
    logic        swapped;
  } res_t;

  res_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef FP_ALIGN_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic res_t dut_res();
    res_t r;
    r = '{op1_sig, op2_sig, op1_sign, op2_sign, eff_sub, big_exp, exp_diff, swapped};
    return r;
  endfunction

  task automatic cmp_res(input string tag, input res_t act, input res_t exp);
    chk({tag, ".op1_sig"},  64'(act.op1_sig),  64'(exp.op1_sig));
    chk({tag, ".op2_sig"},  64'(act.op2_sig),  64'(exp.op2_sig));
    chk({tag, ".op1_sign"}, 64'(act.op1_sign), 64'(exp.op1_sign));
    chk({tag, ".op2_sign"}, 64'(act.op2_sign), 64'(exp.op2_sign));
    chk({tag, ".eff_sub"},  64'(act.eff_sub),  64'(exp.eff_sub));
    chk({tag, ".big_exp"},  64'(act.big_exp),  64'(exp.big_exp));
    chk({tag, ".exp_diff"}, 64'(act.exp_diff), 64'(exp.exp_diff));
    chk({tag, ".swapped"},  64'(act.swapped),  64'(exp.swapped));
  endtask

  // Reference: order by numeric magnitude, then align with a wide shift.
  function automatic res_t model(input logic [63:0] x, input logic [63:0] y, input logic sub);
    res_t r;
    int unsigned ex, ey, e1, e2, d;
    longint unsigned kx, ky, mx, my, m2;
    logic sx, sy, h2;
    logic [55:0]  sig2, data;
    logic [111:0] ext;
    logic s;
    sx = x[63];
    sy = y[63] ^ sub;
    ex = (x[62:52] == 0) ? 1 : int'(x[62:52]);
    ey = (y[62:52] == 0) ? 1 : int'(y[62:52]);
    mx = longint'(x[51:0]);
    my = longint'(y[51:0]);
    kx = longint'(ex) * 64'd4503599627370496 + mx;
    ky = longint'(ey) * 64'd4503599627370496 + my;
    r.swapped = (ky > kx);
    if (r.swapped) begin
      e1 = ey; e2 = ex; h2 = (x[62:52] != 0); m2 = mx;
      r.op1_sign = sy; r.op2_sign = sx;
      r.op1_sig  = {(y[62:52] != 0), y[51:0], 3'b000};
    end else begin
      e1 = ex; e2 = ey; h2 = (y[62:52] != 0); m2 = my;
      r.op1_sign = sx; r.op2_sign = sy;
      r.op1_sig  = {(x[62:52] != 0), x[51:0], 3'b000};
    end
    d          = e1 - e2;
    r.big_exp  = 11'(e1);
    r.exp_diff = 11'(d);
    r.eff_sub  = r.op1_sign ^ r.op2_sign;
    sig2 = {h2, m2[51:0], 3'b000};
    if (d >= SIG_W) begin
      data = '0;
      s    = |sig2;
    end else begin
      ext  = {sig2, 56'd0} >> d;
      data = ext[111:56];
      s    = (|ext[55:0]) | data[0];
    end
    data[0]   = STICKY ? s : 1'b0;
    r.op2_sig = data;
    return r;
  endfunction

  function automatic logic [63:0] rand_op(input logic [63:0] other);
    logic [63:0] m;
    logic        s;
    int unsigned e;
    m = {$urandom, $urandom};
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0: return {s, 63'd0};
      1: return {s, 11'd0, m[51:0]};
      2: return {s, 11'h7FF, ($urandom_range(0, 1) != 0) ? m[51:0] : 52'd0};
      3: return {s, other[62:0]};
      4: return m;
      default: begin
        e = 1023 + $urandom_range(0, 120) - 60;
        return {s, 11'(e), m[51:0]};
      end
    endcase
  endfunction

  // Monitor: pops on every output transfer and checks stall stability.
  res_t held;
  bit   stalled = 1'b0;
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        cmp_res("stall_hold", dut_res(), held);
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got op1_sig %h expected no output", op1_sig);
          end else begin
            cmp_res("result", dut_res(), sb_q.pop_front());
          end
        end else begin
          stalled = 1'b1;
          held    = dut_res();
        end
      end
    end
  end

  task automatic drain();
    int cyc;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_pending", 64'(sb_q.size()), 64'd0);
  endtask

  // Issue one directed pair whose expected result is given explicitly.
  task automatic send_dir(input logic [63:0] x, input logic [63:0] y, input logic sub,
                          input res_t exp);
    int cyc;
    bit done;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'b1;
      a = x; b = y; sub_op = sub; in_valid = 1'b1;
      #1;
      if (in_ready) begin
        sb_q.push_back(exp);
        done = 1'b1;
      end
    end
    chk("dir_accept", 64'(done), 64'd1);
    drain();
  endtask

  // mode 0: random valid/ready; mode 1: valid always, ready 1,0,0,1,...
  task automatic run_stream(input int n, input int mode);
    int sent, cyc;
    bit have;
    bit pat[4];
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
    sent = 0; cyc = 0; have = 1'b0;
    while (sent < n && cyc < 5000) begin
      @(negedge clk);
      out_ready = (mode == 1) ? pat[cyc % 4] : ($urandom_range(0, 3) != 0);
      cyc++;
      if (!have) begin
        if (mode == 1 || $urandom_range(0, 4) != 0) begin
          a        = rand_op(64'd0);
          b        = rand_op(a);
          sub_op   = 1'($urandom_range(0, 1));
          in_valid = 1'b1;
          have     = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      #1;
      if (in_valid && in_ready) begin
        sb_q.push_back(model(a, b, sub_op));
        sent++;
        have = 1'b0;
      end
    end
    chk("stream_sent", 64'(sent), 64'(n));
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub_op = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_op1_sig", 64'(op1_sig), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // 1.0 + 0.5
    e = '{56'h80000000000000, 56'h40000000000000, 1'b0, 1'b0, 1'b0, 11'h3FF, 11'd1, 1'b0};
    send_dir(64'h3FF0000000000000, 64'h3FE0000000000000, 1'b0, e);
    // 0.5 + (-1.0): swap, effective subtract
    e = '{56'h80000000000000, 56'h40000000000000, 1'b1, 1'b0, 1'b1, 11'h3FF, 11'd1, 1'b1};
    send_dir(64'h3FE0000000000000, 64'hBFF0000000000000, 1'b0, e);
    // 2^53 + (1+ulp): shift of 53, only sticky sees the ulp
    e = '{56'h80000000000000, STICKY ? 56'd5 : 56'd4, 1'b0, 1'b0, 1'b0, 11'h434, 11'd53, 1'b0};
    send_dir(64'h4340000000000000, 64'h3FF0000000000001, 1'b0, e);
    // 0 + 0
    e = '{56'd0, 56'd0, 1'b0, 1'b0, 1'b0, 11'd1, 11'd0, 1'b0};
    send_dir(64'd0, 64'd0, 1'b0, e);
    // 1.0 - 1.0: equal magnitude, sub inverts b sign, no swap
    e = '{56'h80000000000000, 56'h80000000000000, 1'b0, 1'b1, 1'b1, 11'h3FF, 11'd0, 1'b0};
    send_dir(64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1, e);

    run_stream(8, 1);
    run_stream(300, 0);

    // Reset with both stages occupied
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    a = rand_op(64'd0); b = rand_op(a); sub_op = 1'b0;
    #1;
    if (in_ready) sb_q.push_back(model(a, b, sub_op));
    @(negedge clk);
    a = rand_op(64'd0); b = rand_op(a); sub_op = 1'b1;
    #1;
    if (in_ready) sb_q.push_back(model(a, b, sub_op));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rerst_in_ready", 64'(in_ready), 64'd1);
    chk("rerst_out_valid", 64'(out_valid), 64'd0);

    run_stream(20, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
